// File: rtl/riscy_mem_pkg.sv
// Shared types for the RISCY fetch/data memory arbiter: request source tags and
// the grant-lock state encoding.
package riscy_mem_pkg;

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
  typedef enum logic {IDLE = 1'b0, WAIT_GNT = 1'b1} lock_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/riscy_tag_fifo.sv
// In-order FIFO of request source tags: one entry per granted request that is
// still waiting for its memory response.
module riscy_tag_fifo
  import riscy_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  src_e             tag_i,
  input  logic             pop_i,
  output src_e             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  src_e             slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = slots[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Tag storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) slots[wr_ptr] <= tag_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscy_mem_arbiter.sv
// Shares one single-port memory between the RISCY fetch and data ports using the
// req/gnt/rvalid protocol, steering in-order responses back via a tag FIFO.
module riscy_mem_arbiter
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              err_o
);

  lock_state_e state_q, state_d;
  src_e        locked_q, locked_d;
  src_e        last_q, last_d;
  logic        err_q, err_d;

  src_e        sel;
  logic        sel_req;
  logic        grant;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  src_e        fifo_head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      locked_q <= SRC_INSTR;
      last_q   <= SRC_INSTR;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Source selection, request muxing and lock/error next-state.
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    last_d   = last_q;
    err_d    = err_q;
    sel      = SRC_INSTR;

    if (state_q == WAIT_GNT) begin
      sel = locked_q;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (data_req_i) begin
      sel = SRC_DATA;
    end

    sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    // Full blocks on registered occupancy only, so rvalid never reaches mem_req_o.
    mem_req_o = rst_ni && sel_req && !fifo_full;
    grant     = mem_req_o && mem_gnt_i;

    if (sel == SRC_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = '0;
    end

    instr_gnt_o = grant && (sel == SRC_INSTR);
    data_gnt_o  = grant && (sel == SRC_DATA);

    if (grant) last_d = sel;

    case (state_q)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d  = WAIT_GNT;
          locked_d = sel;
        end
      end
      WAIT_GNT: begin
        if (grant) state_d = IDLE;
        if (!sel_req) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (mem_rvalid_i && fifo_empty) err_d = 1'b1;

    fifo_pop       = rst_ni && mem_rvalid_i && !fifo_empty;
    instr_rvalid_o = fifo_pop && (fifo_head == SRC_INSTR);
    data_rvalid_o  = fifo_pop && (fifo_head == SRC_DATA);
  end

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign err_o         = err_q;

  riscy_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .tag_i   (sel),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// Directed bench for riscy_mem_arbiter: hand-computed grants, routing, full and
// error behaviour.
module tb_riscy_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  riscy_mem_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_in();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // One response cycle: returns rdata and checks which side sees rvalid.
  task automatic rsp(input string tag, input logic [31:0] rd, input logic to_data);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    settle();
    chk_val({tag, "_irv"}, instr_rvalid_o, !to_data);
    chk_val({tag, "_drv"}, data_rvalid_o, to_data);
    chk_val({tag, "_rdata"}, to_data ? data_rdata_o : instr_rdata_o, rd);
    cyc();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    clr_in();
    rst_ni      = 1'b0;
    instr_req_i = 1'b1;
    mem_gnt_i   = 1'b1;
    #3;
    chk_val("rst_cnt", outstanding_o, 0);
    chk_val("rst_err", err_o, 0);
    chk_val("rst_mreq", mem_req_o, 0);
    chk_val("rst_ignt", instr_gnt_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    clr_in();
    rst_ni = 1'b1;
    cyc();

    // Single fetch
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    mem_gnt_i    = 1'b1;
    settle();
    chk_val("f_ignt", instr_gnt_o, 1);
    chk_val("f_dgnt", data_gnt_o, 0);
    chk_val("f_addr", mem_addr_o, 32'h80);
    chk_val("f_be", mem_be_o, 4'hF);
    chk_val("f_we", mem_we_o, 0);
    chk_val("f_wdata", mem_wdata_o, 0);
    cyc();
    clr_in();
    settle();
    chk_val("f_cnt1", outstanding_o, 1);
    chk_val("f_drv0", data_rvalid_o, 0);
    cyc();
    rsp("f_rsp", 32'h13, 1'b0);
    settle();
    chk_val("f_cnt0", outstanding_o, 0);

    // Contention: data wins first, then alternate
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h400;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h800;
    mem_gnt_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk_val($sformatf("c_dgnt%0d", k), data_gnt_o, (k % 2) == 0);
      chk_val($sformatf("c_ignt%0d", k), instr_gnt_o, (k % 2) == 1);
      cyc();
    end
    settle();
    chk_val("c_cnt4", outstanding_o, 4);
    chk_val("c_mreq_full", mem_req_o, 0);

    // Full boundary: pop and new request together gives no grant
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1;
    settle();
    chk_val("fb_mreq", mem_req_o, 0);
    chk_val("fb_ignt", instr_gnt_o, 0);
    chk_val("fb_drv", data_rvalid_o, 1);
    chk_val("fb_irv", instr_rvalid_o, 0);
    cyc();
    mem_rvalid_i = 1'b0;
    settle();
    chk_val("fb_cnt3", outstanding_o, 3);
    chk_val("fb_ignt_nxt", instr_gnt_o, 1);
    cyc();
    clr_in();
    settle();
    chk_val("fb_cnt4", outstanding_o, 4);
    rsp("d0", 32'h21, 1'b0);
    rsp("d1", 32'h22, 1'b1);
    rsp("d2", 32'h23, 1'b0);
    rsp("d3", 32'h24, 1'b0);
    settle();
    chk_val("d_cnt0", outstanding_o, 0);

    // Gnt stall on a data store; instr joins in cycle 1
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h100;
    data_wdata_i = 32'hDEADBEEF;
    instr_addr_i = 32'h200;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) instr_req_i = 1'b1;
      settle();
      chk_val($sformatf("s_addr%0d", k), mem_addr_o, 32'h100);
      chk_val($sformatf("s_dgnt%0d", k), data_gnt_o, 0);
      chk_val($sformatf("s_ignt%0d", k), instr_gnt_o, 0);
      cyc();
    end
    mem_gnt_i = 1'b1;
    settle();
    chk_val("s_we", mem_we_o, 1);
    chk_val("s_be", mem_be_o, 4'b0011);
    chk_val("s_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk_val("s_dgnt3", data_gnt_o, 1);
    chk_val("s_ignt3", instr_gnt_o, 0);
    cyc();
    data_req_i = 1'b0;
    settle();
    chk_val("s_ignt4", instr_gnt_o, 1);
    chk_val("s_addr4", mem_addr_o, 32'h200);
    cyc();
    clr_in();
    rsp("s_r0", 32'h55, 1'b1);
    rsp("s_r1", 32'h66, 1'b0);
    settle();
    chk_val("s_err", err_o, 0);

    // Ordering: instr, data, instr
    mem_gnt_i   = 1'b1;
    instr_req_i = 1'b1;
    settle();
    chk_val("o_g0", instr_gnt_o, 1);
    cyc();
    instr_req_i = 1'b0;
    data_req_i  = 1'b1;
    settle();
    chk_val("o_g1", data_gnt_o, 1);
    cyc();
    data_req_i  = 1'b0;
    instr_req_i = 1'b1;
    settle();
    chk_val("o_g2", instr_gnt_o, 1);
    cyc();
    clr_in();
    rsp("o_a", 32'hA, 1'b0);
    rsp("o_b", 32'hB, 1'b1);
    rsp("o_c", 32'hC, 1'b0);
    settle();
    chk_val("o_cnt0", outstanding_o, 0);

    // Response with empty FIFO is dropped and flagged
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    settle();
    chk_val("e_irv", instr_rvalid_o, 0);
    chk_val("e_drv", data_rvalid_o, 0);
    cyc();
    mem_rvalid_i = 1'b0;
    settle();
    chk_val("e_err", err_o, 1);
    repeat (3) cyc();
    chk_val("e_err_sticky", err_o, 1);

    // Async reset with two outstanding
    mem_gnt_i   = 1'b1;
    instr_req_i = 1'b1;
    cyc();
    instr_req_i = 1'b0;
    data_req_i  = 1'b1;
    cyc();
    settle();
    chk_val("r_cnt2", outstanding_o, 2);
    instr_req_i = 1'b1;
    rst_ni      = 1'b0;
    #1;
    chk_val("r_cnt0", outstanding_o, 0);
    chk_val("r_ignt", instr_gnt_o, 0);
    chk_val("r_dgnt", data_gnt_o, 0);
    chk_val("r_mreq", mem_req_o, 0);
    chk_val("r_err", err_o, 0);
    cyc();
    clr_in();
    rst_ni = 1'b1;
    cyc();
    mem_rvalid_i = 1'b1;
    settle();
    chk_val("r_late_irv", instr_rvalid_o, 0);
    cyc();
    mem_rvalid_i = 1'b0;
    settle();
    chk_val("r_late_err", err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscy_mem_arbiter.md
Name: riscy_mem_arbiter

Overview:
Shares one single-port memory between the RISCY core's instruction fetch port and data port, using the core's req/gnt/rvalid protocol on all three sides. Arbitrates each cycle and holds a pending request stable until the memory grants it. Records the source of every granted request in an in-order tag FIFO, then steers each mem_rvalid_i/mem_rdata_i response back to that source. Sits between the core (or GUVM_interface driver) and the shared memory model in the riscy testbench.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, read/write data width (also INSTR_RDATA_WIDTH of the core)
MAX_OUTSTANDING, 4, depth of the tag FIFO; maximum granted-but-unanswered requests (power of two, at least 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_W  fetch address
instr_gnt_o  out  1  fetch request accepted this cycle
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_W  fetch response data
data_req_i  in  1  load/store request
data_we_i  in  1  1 means store
data_be_i  in  4  byte enables
data_addr_i  in  ADDR_W  load/store address
data_wdata_i  in  DATA_W  store data
data_gnt_o  out  1  load/store request accepted
data_rvalid_o  out  1  load/store response valid
data_rdata_o  out  DATA_W  load response data
mem_req_o  out  1  request to memory
mem_addr_o  out  ADDR_W  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_i  in  1  memory accepted the request
mem_rvalid_i  in  1  memory response valid, strictly in order
mem_rdata_i  in  DATA_W  memory response data
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values (async, rst_ni=0): FIFO empty, outstanding_o=0, lock state IDLE, last_src=SRC_INSTR (so data wins the first tie), err_o=0. All *_gnt_o, *_rvalid_o and mem_req_o are 0 while in reset.
- Lock FSM has two states:
  - IDLE: selects a source combinationally. If only one source requests, it wins. If both request, the one not equal to last_src wins (round-robin).
  - WAIT_GNT: the selection is forced to locked_src.
  - IDLE -> WAIT_GNT when mem_req_o=1 and mem_gnt_i=0; locked_src is registered at that point.
  - WAIT_GNT -> IDLE on mem_gnt_i=1.
- Full blocking: when outstanding_o == MAX_OUTSTANDING, mem_req_o=0 and no grant is given, even if a response pops in the same cycle. There is no combinational path from mem_rvalid_i to mem_req_o. The FSM state is held while full.
- mem_req_o = (selected source's req) and not full.
- Data source selected: mem_addr/we/be/wdata are taken from the data_* inputs.
- Instruction source selected: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- Grant: <src>_gnt_o = mem_gnt_i and mem_req_o and (sel==src); combinational, same cycle. The other source's gnt is 0.
- On each grant: push sel into the tag FIFO and set last_src=sel.
- Response: mem_rvalid_i pops the FIFO head. The cycle's rvalid goes to the source named by the head tag; rdata is passed through combinationally to both *_rdata_o. Latency is 0 cycles through the arbiter.
- Push and pop in the same cycle leave the count unchanged; the FIFO wraps its pointers modulo MAX_OUTSTANDING.
- mem_rvalid_i with an empty FIFO: set err_o, drop the response, and leave both *_rvalid_o at 0.
- If locked_src drops its req while in WAIT_GNT: set err_o, mem_req_o follows that req (goes to 0), and the FSM stays in WAIT_GNT.
- err_o clears only on reset.
- Reset mid-operation: all in-flight tags are discarded. Any memory response arriving after reset sets err_o.

Decomposition:
- Package riscy_mem_pkg holds:
  - typedef enum logic {SRC_INSTR, SRC_DATA} src_e
  - typedef enum logic {IDLE, WAIT_GNT} lock_state_e
  - localparams ADDR_W_DEF=32 and DATA_W_DEF=32
- One sub-module, riscy_tag_fifo: a synchronous FIFO of src_e, depth MAX_OUTSTANDING, with push/pop/full/empty/count outputs. It uses the same clk_i/rst_ni.

Test Plan:
- Single fetch: instr_req_i=1, instr_addr_i=0x80, mem_gnt_i=1, then mem_rvalid_i=1 with rdata=0x00000013 two cycles later -> instr_gnt_o=1 in cycle 0, mem_be_o=4'hF, mem_we_o=0; instr_rvalid_o=1 with rdata 0x13 in cycle 2; data_rvalid_o=0 throughout.
- Contention: both sources request every cycle with mem_gnt_i=1 and no responses -> grants alternate data, instr, data, instr; after 4 grants outstanding_o=4 and mem_req_o=0.
- Gnt stall: data store to 0x100, wdata 0xDEADBEEF, be 4'b0011, with mem_gnt_i=0 for 3 cycles; instr_req_i rises in cycle 1 -> mem_addr_o stays 0x100 and the data fields stay unchanged until gnt; data_gnt_o=1 in cycle 3; instr is granted next.
- Ordering: grant instr, data, instr, then return responses 0xA, 0xB, 0xC -> instr_rvalid_o receives 0xA, data_rvalid_o receives 0xB, instr_rvalid_o receives 0xC; outstanding_o ends at 0.
- Full boundary: FIFO at 4 entries, with mem_rvalid_i=1 and a new request in the same cycle -> no grant that cycle, count goes to 3, grant issued the next cycle.
- Error/reset: mem_rvalid_i=1 with an empty FIFO -> err_o=1 and stays 1 until rst_ni=0. Asserting reset with 2 entries outstanding -> outstanding_o=0 immediately (asynchronous) and all grants low.
